// File: rtl/cozy_bus_arbiter_if.sv
// Shared bus bundle between the two cozy bus masters, the arbiter and the address decode.
// The arbiter uses the slave view; the master view is the masters' and decoder's side.
interface cozy_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic            m0_req;
    logic            m0_lock;
    logic [AW-1:0]   m0_addr;
    logic [DW/8-1:0] m0_bwe;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt;
    logic            m0_rvalid;

    logic            m1_req;
    logic            m1_lock;
    logic [AW-1:0]   m1_addr;
    logic [DW/8-1:0] m1_bwe;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;

    logic [AW-1:0]   bus_addr;
    logic [DW/8-1:0] bus_bwe;
    logic [DW-1:0]   bus_wdata;
    logic [DW-1:0]   bus_rdata;
    logic [DW-1:0]   m_rdata;

    modport master (
        output m0_req, m0_lock, m0_addr, m0_bwe, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_bwe, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  bus_addr, bus_bwe, bus_wdata, m_rdata
    );

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_bwe, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_bwe, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output bus_addr, bus_bwe, bus_wdata, m_rdata
    );
endinterface

// File: rtl/cozy_bus_arbiter.sv
// Two-master round-robin arbiter for the cozy memory bus, with bounded lock bursts.
// Bus outputs are zero unless the owner is actively transferring.
module cozy_bus_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    cozy_bus_arbiter_if.slave  bus
);
    localparam int BW = DW / 8;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, state_nxt, other_st;
    logic            last;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            rvalid0, rvalid1;
    logic            xfer0, xfer1, xfer;
    logic            own_req, own_lock, oth_req;
    logic [AW-1:0]   addr_mux;
    logic [BW-1:0]   bwe_mux;
    logic [DW-1:0]   wdata_mux;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        if (v >= HW'(MAX_HOLD))
            return HW'(MAX_HOLD);
        return v + 1'b1;
    endfunction

    assign xfer0    = (state == OWN0) && bus.m0_req;
    assign xfer1    = (state == OWN1) && bus.m1_req;
    assign xfer     = xfer0 || xfer1;
    assign own_req  = (state == OWN0) ? bus.m0_req  : bus.m1_req;
    assign own_lock = (state == OWN0) ? bus.m0_lock : bus.m1_lock;
    assign oth_req  = (state == OWN0) ? bus.m1_req  : bus.m0_req;
    assign other_st = (state == OWN0) ? OWN1 : OWN0;

    // The hold comparison uses >= so a counter saturated during an
    // uncontended lock still yields the bus as soon as a waiter appears.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req)
                    state_nxt = last ? OWN0 : OWN1;
                else if (bus.m0_req)
                    state_nxt = OWN0;
                else if (bus.m1_req)
                    state_nxt = OWN1;
            end
            default: begin
                if (!own_req)
                    state_nxt = oth_req ? other_st : IDLE;
                else if (oth_req && (!own_lock || hold_cnt >= HW'(MAX_HOLD - 1)))
                    state_nxt = other_st;
            end
        endcase
    end

    assign hold_nxt = (xfer && own_lock && state_nxt == state) ? sat_inc(hold_cnt) : '0;

    always_comb begin
        addr_mux  = '0;
        bwe_mux   = '0;
        wdata_mux = '0;
        if (xfer0) begin
            addr_mux  = bus.m0_addr;
            bwe_mux   = bus.m0_bwe;
            wdata_mux = bus.m0_wdata;
        end else if (xfer1) begin
            addr_mux  = bus.m1_addr;
            bwe_mux   = bus.m1_bwe;
            wdata_mux = bus.m1_wdata;
        end
    end

    // Registered stage: ownership, fairness history, hold counter, read-valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (xfer0)
                last <= 1'b0;
            else if (xfer1)
                last <= 1'b1;
            rvalid0  <= xfer0 && (bus.m0_bwe == '0);
            rvalid1  <= xfer1 && (bus.m1_bwe == '0);
        end
    end

    assign bus.m0_gnt    = (state == OWN0);
    assign bus.m1_gnt    = (state == OWN1);
    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.bus_addr  = addr_mux;
    assign bus.bus_bwe   = bwe_mux;
    assign bus.bus_wdata = wdata_mux;
    assign bus.m_rdata   = bus.bus_rdata;
endmodule
